mem_responder: RTL and testbench

Memory-side responder for the multicycle datapath's unified instruction/data memory port. It accepts one word request at a time from the control/datapath side (instruction fetch, lw, sw). It serves the request from an internal word-addressed RAM after a fixed, parameterised latency. It returns a response through a valid/ready handshake, so the control FSM can stall on memory instead of assuming single-cycle access.

---
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder.sv | 123 ++++++++++++
 tb/tb_mem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the datapath and the memory responder.
// master = control/datapath side, slave = memory side.
interface mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Unified instruction/data memory responder: one word request at a time,
// served from an internal RAM after a fixed latency, valid/ready response.
module mem_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input logic           clk,
    input logic           rst_n,
    mem_responder_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY >= 2 ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic                  accept;
    logic                  commit;
    logic                  c_we;
    logic                  c_err;
    logic [ADDR_W-1:0]     c_addr;
    logic [DATA_W-1:0]     c_wdata;
    logic [DEPTH_LOG2-1:0] c_idx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        commit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_nx = RESP;
                        commit   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                    commit   = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // With LATENCY=1 the commit happens on the acceptance edge itself,
    // so the live request fields are used instead of the captured ones.
    always_comb begin
        c_we    = (state == IDLE) ? bus.req_we    : we_q;
        c_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
        c_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;
        c_idx   = c_addr[DEPTH_LOG2+1:2];
        c_err   = (c_addr[1:0] != 2'b00) ||
                  ((c_addr >> (DEPTH_LOG2 + 2)) != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (commit) begin
            err_q   <= c_err;
            rdata_q <= (c_we || c_err) ? '0 : mem[c_idx];
        end else if (state == RESP && bus.resp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end
    end

    // RAM has no reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) mem[c_idx] <= c_wdata;
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three builds (LATENCY 2, 1, 15) share one stimulus
// driver; a word-level memory model predicts every response.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic        resp_ready = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    int          sel = 0;

    mem_responder_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
    mem_responder_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    mem_responder_if #(.ADDR_W(32), .DATA_W(32)) b15 ();

    assign b2.req_valid  = req_valid && sel == 0;
    assign b1.req_valid  = req_valid && sel == 1;
    assign b15.req_valid = req_valid && sel == 2;
    assign b2.resp_ready  = resp_ready && sel == 0;
    assign b1.resp_ready  = resp_ready && sel == 1;
    assign b15.resp_ready = resp_ready && sel == 2;
    assign b2.req_we = req_we;
    assign b1.req_we = req_we;
    assign b15.req_we = req_we;
    assign b2.req_addr = req_addr;
    assign b1.req_addr = req_addr;
    assign b15.req_addr = req_addr;
    assign b2.req_wdata = req_wdata;
    assign b1.req_wdata = req_wdata;
    assign b15.req_wdata = req_wdata;

    mem_responder #(.LATENCY(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
    mem_responder #(.LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    mem_responder #(.LATENCY(15)) u15 (.clk(clk), .rst_n(rst_n), .bus(b15.slave));

    logic        o_rdy, o_vld, o_err;
    logic [31:0] o_rdata;
    always_comb begin
        o_rdy = b2.req_ready;
        o_vld = b2.resp_valid;
        o_err = b2.resp_err;
        o_rdata = b2.resp_rdata;
        if (sel == 1) begin
            o_rdy = b1.req_ready;
            o_vld = b1.resp_valid;
            o_err = b1.resp_err;
            o_rdata = b1.resp_rdata;
        end else if (sel == 2) begin
            o_rdy = b15.req_ready;
            o_vld = b15.resp_valid;
            o_err = b15.resp_err;
            o_rdata = b15.resp_rdata;
        end
    end

    int total = 0;
    int bad = 0;
    bit [31:0] model [int];

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : (s == 1) ? 1 : 15;
    endfunction

    function automatic bit exp_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd4096);
    endfunction

    function automatic int key(input int s, input logic [31:0] a);
        return s * 65536 + int'(a / 4);
    endfunction

    // Drives one transaction and reports what the responder did.
    task automatic txn(input int s, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input int hold,
                       output int lat, output logic [31:0] rd,
                       output logic er, output bit stable, output bit idle_ok);
        int w;
        sel = s;
        @(negedge clk);
        req_we = we;
        req_addr = a;
        req_wdata = d;
        req_valid = 1'b1;
        resp_ready = 1'b0;
        w = 0;
        while (!o_rdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!o_vld && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = o_rdata;
        er = o_err;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (!(o_vld === 1'b1 && o_rdata === rd && o_err === er && o_rdy === 1'b0))
                stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        idle_ok = (o_vld === 1'b0 && o_rdy === 1'b1 && o_rdata === 32'd0 && o_err === 1'b0);
    endtask

    task automatic test_reset();
        sel = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (o_rdy !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_rdy); end
        total++;
        if (o_vld !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_vld); end
        total++;
        if (o_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", o_rdata); end
        total++;
        if (o_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", o_err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er; bit st, ok;
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, lat, rd, er, st, ok);
        model[key(0, 32'h10)] = 32'hDEADBEEF;
        total++;
        if (lat != 2) begin bad++; $display("FAIL st_lat got=%0d exp=2", lat); end
        total++;
        if (er !== 1'b0 || rd !== 32'd0) begin bad++; $display("FAIL st_resp got=%b/%h exp=0/0", er, rd); end
        total++;
        if (!ok) begin bad++; $display("FAIL st_idle got=0 exp=1"); end
        txn(0, 1'b0, 32'h10, 32'h0, 0, lat, rd, er, st, ok);
        total++;
        if (lat != 2) begin bad++; $display("FAIL ld_lat got=%0d exp=2", lat); end
        total++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL ld_data got=%h/%b exp=deadbeef/0", rd, er); end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd; logic er; bit st, ok;
        txn(0, 1'b0, 32'h10, 32'h0, 5, lat, rd, er, st, ok);
        total++;
        if (!st) begin bad++; $display("FAIL bp_stable got=0 exp=1"); end
        total++;
        if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL bp_data got=%h exp=deadbeef", rd); end
        total++;
        if (!ok) begin bad++; $display("FAIL bp_release got=0 exp=1"); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er; bit st, ok;
        txn(0, 1'b1, 32'h12, 32'h55AA55AA, 0, lat, rd, er, st, ok);
        total++;
        if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL err_mis got=%b/%h exp=1/0", er, rd); end
        txn(0, 1'b0, 32'h10, 32'h0, 0, lat, rd, er, st, ok);
        total++;
        if (rd !== model[key(0, 32'h10)]) begin bad++; $display("FAIL err_keep got=%h exp=%h", rd, model[key(0, 32'h10)]); end
        txn(0, 1'b0, 32'h1000, 32'h0, 1, lat, rd, er, st, ok);
        total++;
        if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL err_oor got=%b/%h exp=1/0", er, rd); end
        total++;
        if (lat != 2) begin bad++; $display("FAIL err_lat got=%0d exp=2", lat); end
    endtask

    task automatic test_busy_ignore();
        int lat; logic [31:0] rd; logic er; bit st, ok;
        txn(0, 1'b1, 32'h20, 32'hA5A50020, 0, lat, rd, er, st, ok);
        model[key(0, 32'h20)] = 32'hA5A50020;
        @(negedge clk);
        req_we = 1'b0;
        req_addr = 32'h10;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        req_we = 1'b1;
        req_addr = 32'h20;
        req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (o_vld !== 1'b1 || o_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL busy_resp got=%b/%h exp=1/deadbeef", o_vld, o_rdata); end
        @(negedge clk);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        txn(0, 1'b0, 32'h20, 32'h0, 0, lat, rd, er, st, ok);
        total++;
        if (rd !== 32'hA5A50020) begin bad++; $display("FAIL busy_ignore got=%h exp=a5a50020", rd); end
    endtask

    task automatic test_reset_midop();
        int lat; logic [31:0] rd; logic er; bit st, ok;
        txn(0, 1'b1, 32'h30, 32'h0BAD0030, 0, lat, rd, er, st, ok);
        model[key(0, 32'h30)] = 32'h0BAD0030;
        @(negedge clk);
        req_we = 1'b1;
        req_addr = 32'h30;
        req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (o_rdy !== 1'b1 || o_vld !== 1'b0 || o_rdata !== 32'd0 || o_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_async got=%b%b/%h/%b exp=10/0/0", o_rdy, o_vld, o_rdata, o_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        txn(0, 1'b0, 32'h30, 32'h0, 0, lat, rd, er, st, ok);
        total++;
        if (rd !== 32'h0BAD0030) begin bad++; $display("FAIL rst_nowrite got=%h exp=0bad0030", rd); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; logic er; bit st, ok;
        int s, hold, kind;
        bit we;
        logic [31:0] a, d, exp_rd;
        for (int ss = 0; ss < 3; ss++) begin
            for (int i = 0; i < 16; i++) begin
                a = 32'h100 + 32'(i * 4);
                d = $urandom;
                txn(ss, 1'b1, a, d, 0, lat, rd, er, st, ok);
                model[key(ss, a)] = d;
            end
        end
        for (int n = 0; n < 40; n++) begin
            s = int'($urandom_range(0, 2));
            kind = int'($urandom_range(0, 9));
            we = 1'($urandom);
            d = $urandom;
            hold = int'($urandom_range(0, 3));
            a = 32'h100 + 32'($urandom_range(0, 15) * 4);
            if (kind == 0) a = a + 32'($urandom_range(1, 3));
            if (kind == 1) a = 32'h1000 | ($urandom & 32'hFFFFFFFC) | 32'h100;
            txn(s, we, a, d, hold, lat, rd, er, st, ok);
            exp_rd = (we || exp_err(a)) ? 32'd0 : model[key(s, a & 32'hFFF)];
            total++;
            if (lat != lat_of(s)) begin bad++; $display("FAIL rnd_lat s=%0d got=%0d exp=%0d", s, lat, lat_of(s)); end
            total++;
            if (er !== exp_err(a)) begin bad++; $display("FAIL rnd_err a=%h got=%b exp=%b", a, er, exp_err(a)); end
            total++;
            if (rd !== exp_rd) begin bad++; $display("FAIL rnd_data s=%0d a=%h got=%h exp=%h", s, a, rd, exp_rd); end
            total++;
            if (!st || !ok) begin bad++; $display("FAIL rnd_hs s=%0d got=%b%b exp=11", s, st, ok); end
            if (we && !exp_err(a)) model[key(s, a)] = d;
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int l;
        for (int s = 0; s < 3; s++) begin
            acc.delete();
            l = lat_of(s);
            sel = s;
            @(negedge clk);
            req_we = 1'b0;
            req_addr = 32'h104;
            req_valid = 1'b1;
            resp_ready = 1'b1;
            for (int c = 0; c < 3 * (l + 1) + 1; c++) begin
                if (o_rdy === 1'b1) acc.push_back(c);
                @(negedge clk);
            end
            req_valid = 1'b0;
            repeat (l + 3) @(negedge clk);
            resp_ready = 1'b0;
            total++;
            if (acc.size() < 3) begin
                bad++;
                $display("FAIL b2b_count s=%0d got=%0d exp=3", s, acc.size());
            end else begin
                total++;
                if (acc[1] - acc[0] != l + 1 || acc[2] - acc[1] != l + 1) begin
                    bad++;
                    $display("FAIL b2b_space s=%0d got=%0d,%0d exp=%0d", s, acc[1] - acc[0], acc[2] - acc[1], l + 1);
                end
            end
            total++;
            if (o_rdy !== 1'b1 || o_vld !== 1'b0) begin bad++; $display("FAIL b2b_drain s=%0d got=%b%b exp=10", s, o_rdy, o_vld); end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_backpressure();
        test_errors();
        test_busy_ignore();
        test_reset_midop();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
